// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, frame format
// constants and a counter-width helper.
package uart_pkg;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   localparam int   UART_DATA_BITS  = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

   // Counter width able to hold n-1; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_fifo_tx_if.sv
// Byte-producer side of the UART transmitter: valid/ready byte push plus
// line and status outputs.
interface uart_fifo_tx_if #(
   parameter int FIFO_DEPTH = 8
);
   import uart_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [UART_DATA_BITS-1:0] data_in;
   logic                      data_in_valid;
   logic                      data_in_ready;
   logic                      serial_out;
   logic                      busy;
   logic [CW-1:0]             fifo_count;

   modport master (
      output data_in, data_in_valid,
      input  data_in_ready, serial_out, busy, fifo_count
   );

   modport slave (
      input  data_in, data_in_valid,
      output data_in_ready, serial_out, busy, fifo_count
   );

endinterface

// File: rtl/uart_tx_sync_fifo.sv
// Synchronous FIFO with registered count; push is ignored when full and pop
// is ignored when empty, so callers may request either unconditionally.
module uart_tx_sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointers are exactly log2(DEPTH) wide, so they wrap without compare logic.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/uart_fifo_tx.sv
// Buffered 8N1 UART transmitter: bytes pushed over valid/ready are queued and
// shifted out LSB first, back to back when the queue stays non-empty.
module uart_fifo_tx
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 33_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int FIFO_DEPTH = 8
) (
   input logic           clk,
   input logic           rst,
   uart_fifo_tx_if.slave bus
);

   localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
   localparam int BW = cnt_w(SYMBOL_EDGE_TIME);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BW-1:0] BAUD_LOAD = BW'(SYMBOL_EDGE_TIME - 1);
   localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

   tx_state_e                 state_q;
   logic [BW-1:0]             baud_q;
   logic [2:0]                bit_q;
   logic [UART_DATA_BITS-1:0] shift_q;
   logic                      tx_q;

   logic [UART_DATA_BITS-1:0] head;
   logic                      full, empty, baud_zero, pop;
   logic [CW-1:0]             count;

   assign baud_zero = (baud_q == '0);
   // Pop only looks at the registered count, so a byte pushed this edge waits.
   assign pop = !empty && ((state_q == TX_IDLE) ||
                           (state_q == TX_STOP && baud_zero));

   uart_tx_sync_fifo #(
      .WIDTH (UART_DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (bus.data_in_valid),
      .wdata_i (bus.data_in),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= TX_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= UART_IDLE_LEVEL;
      end else begin
         case (state_q)
            TX_IDLE: begin
               if (pop) begin
                  shift_q <= head;
                  tx_q    <= ~UART_IDLE_LEVEL;
                  baud_q  <= BAUD_LOAD;
                  state_q <= TX_START;
               end
            end
            TX_START: begin
               if (baud_zero) begin
                  tx_q    <= shift_q[0];
                  bit_q   <= '0;
                  baud_q  <= BAUD_LOAD;
                  state_q <= TX_DATA;
               end else begin
                  baud_q <= baud_q - 1'b1;
               end
            end
            TX_DATA: begin
               if (baud_zero) begin
                  baud_q <= BAUD_LOAD;
                  if (bit_q == LAST_BIT) begin
                     tx_q    <= UART_IDLE_LEVEL;
                     state_q <= TX_STOP;
                  end else begin
                     tx_q    <= shift_q[1];
                     shift_q <= shift_q >> 1;
                     bit_q   <= bit_q + 1'b1;
                  end
               end else begin
                  baud_q <= baud_q - 1'b1;
               end
            end
            TX_STOP: begin
               if (baud_zero) begin
                  // Chain straight into the next start bit when data is queued.
                  if (pop) begin
                     shift_q <= head;
                     tx_q    <= ~UART_IDLE_LEVEL;
                     baud_q  <= BAUD_LOAD;
                     state_q <= TX_START;
                  end else begin
                     state_q <= TX_IDLE;
                  end
               end else begin
                  baud_q <= baud_q - 1'b1;
               end
            end
            default: state_q <= TX_IDLE;
         endcase
      end
   end

   assign bus.data_in_ready = !full;
   assign bus.serial_out    = tx_q;
   assign bus.busy          = (state_q != TX_IDLE) || !empty;
   assign bus.fifo_count    = count;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx: accepted bytes go into a scoreboard queue, a line
// monitor decodes 8N1 frames mid-bit and compares them in order.
module tb_uart_fifo_tx;
   import uart_pkg::*;

   localparam int S = 16;
   localparam int D = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;

   uart_fifo_tx_if #(.FIFO_DEPTH(D)) bus ();

   uart_fifo_tx #(
      .CLOCK_FREQ (16),
      .BAUD_RATE  (1),
      .FIFO_DEPTH (D)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0;
   int cyc = 0;
   logic [7:0] exp_q[$];
   int starts[$];
   int acc_total = 0, started = 0, last_acc = 0;
   bit mon_act = 0;
   int phase = 0;
   logic [9:0] fr;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Line monitor plus occupancy model: queued = accepted - frames started.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         mon_act = 0;
      end else begin
         if (!mon_act) begin
            if (bus.serial_out == 1'b0) begin
               mon_act = 1;
               phase = 0;
               started++;
               starts.push_back(cyc);
            end
         end else begin
            phase++;
         end
         if (mon_act && (phase % S) == S / 2) begin
            fr[phase / S] = bus.serial_out;
            if (phase / S == 9) begin
               mon_act = 0;
               check("start_bit", int'(fr[0]), 0);
               check("stop_bit", int'(fr[9]), 1);
               if (exp_q.size() == 0) check("unexpected_frame", int'(fr[8:1]), -1);
               else check("frame_byte", int'(fr[8:1]), int'(exp_q.pop_front()));
            end
         end
         check("fifo_count", int'(bus.fifo_count), acc_total - started);
         check("ready", int'(bus.data_in_ready), int'((acc_total - started) != D));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      int n = 0;
      bit acc;
      bus.data_in = b;
      bus.data_in_valid = 1'b1;
      do begin
         acc = bus.data_in_ready;
         @(posedge clk);
         if (acc) begin
            exp_q.push_back(b);
            acc_total++;
         end
         #1;
         n++;
      end while (!acc && n < 2000);
      if (acc) last_acc = cyc;
      else check("push_timeout", 0, 1);
      bus.data_in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((bus.busy || exp_q.size() != 0 || mon_act) && n < 5000) begin
         tick();
         n++;
      end
      check("idle_timeout", int'(n < 5000), 1);
   endtask

   initial begin
      int n, lows;
      bit acc;
      bus.data_in = '0;
      bus.data_in_valid = 1'b0;
      repeat (3) tick();
      check("rst_serial", int'(bus.serial_out), 1);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_count", int'(bus.fifo_count), 0);
      check("rst_ready", int'(bus.data_in_ready), 1);
      rst = 1'b1;
      tick();

      // single byte: latency and frame length
      starts.delete();
      push(8'hA5);
      check("t1_count", int'(bus.fifo_count), 1);
      check("t1_busy", int'(bus.busy), 1);
      check("t1_line_high", int'(bus.serial_out), 1);
      tick();
      check("t1_line_fall", int'(bus.serial_out), 0);
      n = 1;
      while (bus.busy && n < 400) begin
         tick();
         n++;
      end
      check("t1_busy_len", n, 161);
      wait_idle();
      check("t1_latency", starts.size() > 0 ? starts[0] - last_acc : -1, 1);

      // back-to-back frames
      starts.delete();
      push(8'h00);
      check("t2_count_a", int'(bus.fifo_count), 1);
      push(8'hFF);
      check("t2_count_b", int'(bus.fifo_count), 1);
      push(8'h55);
      check("t2_count_c", int'(bus.fifo_count), 2);
      wait_idle();
      check("t2_frames", starts.size(), 3);
      if (starts.size() == 3) begin
         check("t2_gap1", starts[1] - starts[0], 160);
         check("t2_gap2", starts[2] - starts[1], 160);
      end
      check("t2_count_end", int'(bus.fifo_count), 0);

      // fill past full with held valid
      starts.delete();
      for (int i = 0; i < 6; i++) push(8'(8'h10 + 8'(i * 17)));
      check("t3_late_accept", starts.size() > 1 ? last_acc - starts[1] : -1, 1);
      wait_idle();
      check("t3_frames", starts.size(), 6);

      // asynchronous reset during data bit 3
      push(8'h3C);
      repeat (73) tick();
      #3;
      rst = 1'b0;
      exp_q.delete();
      acc_total = 0;
      started = 0;
      #1;
      check("t4_serial", int'(bus.serial_out), 1);
      check("t4_count", int'(bus.fifo_count), 0);
      check("t4_busy", int'(bus.busy), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      lows = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (!bus.serial_out) lows++;
      end
      check("t4_quiet", lows, 0);

      // push landing on the final stop edge gives one idle cycle
      starts.delete();
      push(8'h96);
      repeat (160) tick();
      push(8'h69);
      wait_idle();
      check("t6_frames", starts.size(), 2);
      if (starts.size() == 2) begin
         check("t6_stop_edge", last_acc - starts[0], 160);
         check("t6_gap", starts[1] - starts[0], 161);
      end

      // random valid with changing data while full
      for (int i = 0; i < 3000; i++) begin
         bus.data_in = 8'($urandom);
         bus.data_in_valid = ($urandom_range(0, 3) != 0);
         acc = bus.data_in_valid && bus.data_in_ready;
         @(posedge clk);
         if (acc) begin
            exp_q.push_back(bus.data_in);
            acc_total++;
         end
         #1;
      end
      bus.data_in_valid = 1'b0;
      wait_idle();
      check("final_queue", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
